cnn_frame_infer_ctrl: RTL

//  Streaming front/back end for the combinational CNN compute core. Collects one

---
 rtl/cnn_frame_infer_ctrl_pkg.sv | 24 ++
 rtl/cnn_frame_infer_ctrl_if.sv | 32 +++
 rtl/seq_argmax.sv | 63 ++++++
 rtl/cnn_frame_infer_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cnn_frame_infer_ctrl_pkg.sv
// cnn_pkg: shared types and default sizes for the CNN frame inference control
// path. Imported by the interface, the argmax sub-module and the top.
//   DATA_W   pixel width (Q16.16 signed)
//   LOGIT_W  logit width (signed)
//   N_CLASS  number of logits / classes
//   IDX_W    class index width, derived from N_CLASS
package cnn_pkg;

    localparam int DATA_W  = 32;
    localparam int LOGIT_W = 40;
    localparam int N_CLASS = 10;
    localparam int IDX_W   = $clog2(N_CLASS);

    typedef logic signed [DATA_W-1:0]  pixel_t;
    typedef logic signed [LOGIT_W-1:0] logit_t;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        SCAN,
        HOLD
    } ctrl_state_t;

endpackage

// File: rtl/cnn_frame_infer_ctrl_if.sv
// cnn_frame_infer_ctrl_if: pixel input stream and result output stream.
//   s_valid/s_ready/s_data/s_last  pixel stream (master drives valid/data/last)
//   m_valid/m_ready/m_class/m_score result stream (slave drives valid/class/score)
// modport master: stream source / result sink (the environment)
// modport slave : the controller
interface cnn_frame_infer_ctrl_if #(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int LOGIT_W = cnn_pkg::LOGIT_W,
    parameter int IDX_W   = cnn_pkg::IDX_W
);
    import cnn_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [IDX_W-1:0]   m_class;
    logic [LOGIT_W-1:0] m_score;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_score
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_score
    );

endinterface

// File: rtl/seq_argmax.sv
// seq_argmax: sequential argmax, one signed compare per cycle.
//   clk, rst   clock / synchronous active-high reset
//   i_start    pulse: sample logit 0 as the running best, begin scanning at 1
//   i_logits   live logits vector, must stay stable while scanning
//   o_done     one-cycle pulse after the last logit has been compared
//   o_idx      index of the maximum (lowest index wins ties)
//   o_score    logit value at o_idx
module seq_argmax #(
    parameter int N_CLASS = 10,
    parameter int LOGIT_W = 40,
    localparam int IDX_W  = $clog2(N_CLASS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [N_CLASS-1:0][LOGIT_W-1:0]  i_logits,
    output logic                             o_done,
    output logic [IDX_W-1:0]                 o_idx,
    output logic [LOGIT_W-1:0]               o_score
);
    import cnn_pkg::*;

    logic                      r_busy;
    logic                      r_done;
    logic [IDX_W-1:0]          r_i;
    logic [IDX_W-1:0]          r_idx;
    logic signed [LOGIT_W-1:0] r_best;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_i    <= '0;
            r_idx  <= '0;
            r_best <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_best <= i_logits[0];
                r_idx  <= '0;
                r_i    <= IDX_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                // strict > keeps the earlier index on ties
                if ($signed(i_logits[r_i]) > r_best) begin
                    r_best <= i_logits[r_i];
                    r_idx  <= r_i;
                end
                if (r_i == IDX_W'(N_CLASS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end
        end
    end

    assign o_done  = r_done;
    assign o_idx   = r_idx;
    assign o_score = r_best;

endmodule

// File: rtl/cnn_frame_infer_ctrl.sv
// cnn_frame_infer_ctrl: collects one frame of pixels into a register buffer,
// holds it on frame_out for the combinational core, waits CNN_LAT cycles, runs
// a sequential argmax over the core logits and presents class/score.
//   clk, rst   clock / synchronous active-high reset
//   bus        slave side of the pixel and result streams
//   frame_out  buffered image, all pixels in parallel
//   logits_in  core output logits (signed)
//   frame_err  one-cycle pulse on a short or long frame
module cnn_frame_infer_ctrl #(
    parameter int N_PIX   = 784,
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int N_CLASS = cnn_pkg::N_CLASS,
    parameter int LOGIT_W = cnn_pkg::LOGIT_W,
    parameter int CNN_LAT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    cnn_frame_infer_ctrl_if.slave            bus,
    output logic [N_PIX-1:0][DATA_W-1:0]     frame_out,
    input  logic [N_CLASS-1:0][LOGIT_W-1:0]  logits_in,
    output logic                             frame_err
);
    import cnn_pkg::*;

    localparam int IDX_W = $clog2(N_CLASS);
    localparam int PIX_W = $clog2(N_PIX);
    localparam int LAT_W = $clog2(CNN_LAT + 1);

    ctrl_state_t                r_state;
    logic [PIX_W-1:0]           r_pix;
    logic [LAT_W-1:0]           r_lat;
    logic [N_PIX-1:0][DATA_W-1:0] r_frame;
    logic                       r_s_ready;
    logic                       r_m_valid;
    logic [IDX_W-1:0]           r_m_class;
    logic [LOGIT_W-1:0]         r_m_score;
    logic                       r_frame_err;

    logic                       w_acc;
    logic                       w_start;
    logic                       w_done;
    logic [IDX_W-1:0]           w_idx;
    logic [LOGIT_W-1:0]         w_score;

    // s_ready is only ever high in LOAD, so it alone qualifies an accept
    assign w_acc   = bus.s_valid & r_s_ready;
    // argmax samples logit 0 on the same edge that WAIT hands over to SCAN
    assign w_start = (r_state == WAIT) && (r_lat == LAT_W'(CNN_LAT - 1));

    seq_argmax #(
        .N_CLASS (N_CLASS),
        .LOGIT_W (LOGIT_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_logits (logits_in),
        .o_done   (w_done),
        .o_idx    (w_idx),
        .o_score  (w_score)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_pix       <= '0;
            r_lat       <= '0;
            r_frame     <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_class   <= '0;
            r_m_score   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_s_ready <= 1'b1;
                    if (w_acc) begin
                        r_frame[r_pix] <= bus.s_data;
                        if (r_pix == PIX_W'(N_PIX - 1)) begin
                            // full frame; a missing s_last is flagged but kept
                            r_frame_err <= ~bus.s_last;
                            r_state     <= WAIT;
                            r_lat       <= '0;
                            r_s_ready   <= 1'b0;
                        end else if (bus.s_last) begin
                            r_frame_err <= 1'b1;
                            r_pix       <= '0;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (r_lat == LAT_W'(CNN_LAT - 1)) begin
                        r_state <= SCAN;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                SCAN: begin
                    if (w_done) begin
                        r_state   <= HOLD;
                        r_m_valid <= 1'b1;
                        r_m_class <= w_idx;
                        r_m_score <= w_score;
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= LOAD;
                        r_pix     <= '0;
                        r_s_ready <= 1'b1;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_class = r_m_class;
    assign bus.m_score = r_m_score;
    assign frame_out   = r_frame;
    assign frame_err   = r_frame_err;

endmodule
